// File: rtl/div_seq_pkg.sv
// Shared definitions for the multi-cycle divider sequencer.
// State encodings, handshake levels and bus widths used by div_seq and div_step.
package div_seq_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// The partial remainder lives in work[2W:W]; quotient bits shift in at the LSB.
module div_step
   import div_seq_pkg::*;
#(
   parameter int WIDTH = RegBus
) (
   input  logic [2*WIDTH:0] work_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [2*WIDTH:0] work_o
);

   logic [WIDTH:0] diff;

   // Trial subtraction: keep the difference and shift in a 1, or restore and shift in a 0
   always_comb begin
      diff = work_i[2*WIDTH:WIDTH] - {1'b0, divisor_i};
      if (diff[WIDTH]) begin
         work_o = {work_i[2*WIDTH-1:0], 1'b0};
      end else begin
         work_o = {diff[WIDTH-1:0], work_i[WIDTH-1:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer for the EX stage.
// Produces {remainder, quotient} after WIDTH iterations and stalls the pipe while busy.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero_o output.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = RegBus
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
`ifdef DIV_ZERO_FLAG_EN
   output logic               div_zero_o,
`endif
   output logic               busy_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH:0]   work_q, work_d;
   logic [2*WIDTH:0]   step_work;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic               dividend_neg_q, dividend_neg_d;
   logic               divisor_neg_q, divisor_neg_d;
   logic               signed_q, signed_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   dividend_mag;
   logic [WIDTH-1:0]   divisor_mag;
   logic [WIDTH-1:0]   quot_raw;
   logic [WIDTH-1:0]   rem_raw;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               last_iter;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .work_i   (work_q),
      .divisor_i(divisor_q),
      .work_o   (step_work)
   );

   // Operand magnitudes at issue, and sign-corrected result from the final iteration
   always_comb begin
      dividend_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      divisor_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      quot_raw     = step_work[WIDTH-1:0];
      rem_raw      = step_work[2*WIDTH:WIDTH+1];
      quot_fix     = (signed_q && (dividend_neg_q ^ divisor_neg_q)) ? -quot_raw : quot_raw;
      rem_fix      = (signed_q && dividend_neg_q) ? -rem_raw : rem_raw;
      last_iter    = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Sequencer next-state: issue, iterate, hold the result, or abandon on annul
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      work_d         = work_q;
      divisor_d      = divisor_q;
      dividend_neg_d = dividend_neg_q;
      divisor_neg_d  = divisor_neg_q;
      signed_d       = signed_q;
      result_d       = result_q;
      case (state_q)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  state_d        = DivOn;
                  divisor_d      = divisor_mag;
                  dividend_neg_d = opdata1_i[WIDTH-1];
                  divisor_neg_d  = opdata2_i[WIDTH-1];
                  signed_d       = signed_div_i;
                  work_d         = {{WIDTH{1'b0}}, dividend_mag, 1'b0};
                  cnt_d          = '0;
               end
            end
         end
         DivByZero: begin
            if (annul_i) begin
               state_d = DivFree;
            end else begin
               state_d  = DivEnd;
               result_d = '0;
            end
         end
         DivOn: begin
            if (annul_i) begin
               state_d = DivFree;
            end else begin
               work_d = step_work;
               cnt_d  = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  state_d  = DivEnd;
                  result_d = {rem_fix, quot_fix};
               end
            end
         end
         DivEnd: begin
            if (annul_i || start_i == DivStop) begin
               state_d = DivFree;
            end
         end
         default: state_d = DivFree;
      endcase
   end

   // Sequencer registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= DivFree;
         cnt_q          <= '0;
         work_q         <= '0;
         divisor_q      <= '0;
         dividend_neg_q <= 1'b0;
         divisor_neg_q  <= 1'b0;
         signed_q       <= 1'b0;
         result_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         work_q         <= work_d;
         divisor_q      <= divisor_d;
         dividend_neg_q <= dividend_neg_d;
         divisor_neg_q  <= divisor_neg_d;
         signed_q       <= signed_d;
         result_q       <= result_d;
      end
   end

   // Handshake outputs; busy drops in the result cycle so the stall releases immediately
   always_comb begin
      result_o = result_q;
      ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
      busy_o   = (state_q == DivOn) || (state_q == DivByZero) ||
                 ((state_q == DivFree) && (start_i == DivStart) && !annul_i);
   end

`ifdef DIV_ZERO_FLAG_EN
   logic zero_q, zero_d;

   // Remember whether the current operation went through the divide-by-zero path
   always_comb begin
      zero_d = zero_q;
      if (state_q == DivFree && state_d == DivByZero) begin
         zero_d = 1'b1;
      end else if (state_q == DivFree && state_d == DivOn) begin
         zero_d = 1'b0;
      end
   end

   // Divide-by-zero marker register
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   // Flag is only visible alongside a valid result
   always_comb begin
      div_zero_o = ready_o && zero_q;
   end
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq (WIDTH=32).
// A transaction-level model computes quotient/remainder with plain arithmetic and
// tracks latency; a compare process checks busy/ready/result every cycle.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        annul;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;
`ifdef DIV_ZERO_FLAG_EN
   logic        div_zero_o;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // model state: 0 = idle, 1 = operation in flight, 2 = result being held
   int          m_mode = 0;
   int          m_left = 0;
   logic [63:0] m_pend = '0;
   logic [63:0] m_res  = '0;
   bit          m_pzero = 0;
   bit          m_zero  = 0;

   div_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .annul_i     (annul),
      .signed_div_i(signed_div),
      .opdata1_i   (opdata1),
      .opdata2_i   (opdata2),
      .result_o    (result_o),
      .ready_o     (ready_o),
`ifdef DIV_ZERO_FLAG_EN
      .div_zero_o  (div_zero_o),
`endif
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (!s) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // behavioural model: result and latency from the operands sampled at issue
   always @(posedge clk) begin
      if (rst) begin
         m_mode <= 0;
         m_res  <= '0;
         m_zero <= 0;
      end else begin
         case (m_mode)
            0: if (start && !annul) begin
                  m_pend  <= ref_div(opdata1, opdata2, signed_div);
                  m_pzero <= (opdata2 == 32'd0);
                  m_left  <= (opdata2 == 32'd0) ? 1 : 32;
                  m_mode  <= 1;
               end
            1: if (annul) m_mode <= 0;
               else if (m_left == 1) begin
                  m_mode <= 2;
                  m_res  <= m_pend;
                  m_zero <= m_pzero;
               end else m_left <= m_left - 1;
            default: if (annul || !start) m_mode <= 0;
         endcase
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check_output("busy", {63'd0, busy_o},
                      {63'd0, (m_mode == 1) || (m_mode == 0 && start && !annul)});
         check_output("ready", {63'd0, ready_o}, {63'd0, m_mode == 2});
         check_output("result", result_o, m_res);
`ifdef DIV_ZERO_FLAG_EN
         check_output("div_zero", {63'd0, div_zero_o}, {63'd0, (m_mode == 2) && m_zero});
`endif
      end
   end

   // one division: issue, optionally scramble operands mid-run, wait for ready, release
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input bit use_lit, input logic [63:0] lit, input bit scramble);
      int cyc;
      bit got;
      opdata1    = a;
      opdata2    = b;
      signed_div = s;
      annul      = 1'b0;
      start      = 1'b1;
      cyc = 0;
      got = 0;
      while (!got && cyc < 100) begin
         step();
         cyc++;
         if (ready_o === 1'b1) got = 1;
         else if (scramble) begin
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
         end
      end
      check_output("latency", 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
      if (use_lit) check_output("literal result", result_o, lit);
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 3) == 0) annul = 1'b1;
      else start = 1'b0;
      step();
      check_output("ready released", {63'd0, ready_o}, 64'd0);
      annul = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a, b;
      int r;
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
      opdata1 = '0; opdata2 = '0;
      step();
      step();
      chk_en = 1;
      check_output("reset result", result_o, 64'd0);
      check_output("reset ready", {63'd0, ready_o}, 64'd0);
      check_output("reset busy", {63'd0, busy_o}, 64'd0);
      rst = 1'b0;
      step();

      $display("[TB] directed cases");
      apply_stimulus(32'd100, 32'd7, 1'b0, 1, {32'h2, 32'hE}, 0);
      apply_stimulus(32'hFFFFFFF9, 32'd2, 1'b1, 1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1);
      apply_stimulus(32'd7, 32'hFFFFFFFE, 1'b1, 1, {32'h1, 32'hFFFFFFFD}, 1);
      apply_stimulus(32'h12345678, 32'd0, 1'b0, 1, 64'd0, 0);
      apply_stimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, {32'h0, 32'h80000000}, 1);
      apply_stimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1, {32'h0, 32'hFFFFFFFF}, 1);

      $display("[TB] annul mid-run");
      opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
      repeat (10) step();
      annul = 1'b1;
      start = 1'b0;
      step();
      annul = 1'b0;
      check_output("annul busy", {63'd0, busy_o}, 64'd0);
      check_output("annul ready", {63'd0, ready_o}, 64'd0);
      apply_stimulus(32'd9, 32'd3, 1'b0, 1, {32'h0, 32'h3}, 0);

      $display("[TB] annul in divide-by-zero");
      opdata1 = 32'd55; opdata2 = 32'd0; start = 1'b1;
      step();
      annul = 1'b1;
      start = 1'b0;
      step();
      annul = 1'b0;
      check_output("annul byzero ready", {63'd0, ready_o}, 64'd0);
      check_output("annul byzero keeps result", result_o, {32'h0, 32'h3});
      step();

      $display("[TB] reset mid-run");
      opdata1 = 32'd1234; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
      repeat (15) step();
      rst = 1'b1;
      step();
      check_output("rst result", result_o, 64'd0);
      check_output("rst ready", {63'd0, ready_o}, 64'd0);
      check_output("rst busy follows start", {63'd0, busy_o}, 64'd1);
      rst = 1'b0;
      start = 1'b0;
      #1;
      check_output("rst busy idle", {63'd0, busy_o}, 64'd0);
      step();

      $display("[TB] random cases");
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: b = 32'd0;
            1: b = 32'd1;
            2: b = 32'hFFFFFFFF;
            3: b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         apply_stimulus(a, b, 1'($urandom_range(0, 1)), 0, 64'd0, 1);
      end

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle divider sequencer in the EX stage. Serves DIV/DIVU.
- Runs a radix-2 restoring division over WIDTH cycles.
- Raises a stall request while busy, so EX/MEM and the earlier stages hold.
- Delivers {remainder, quotient} for the HI/LO write path: HI = remainder, LO = quotient.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset (synchronous, active-high)
- start_i  input  1  divide request from EX; held high until the result is consumed
- annul_i  input  1  cancel the in-flight divide (flush/exception)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- result_o  output  2*WIDTH  {remainder, quotient}; valid when ready_o=1
- ready_o  output  1  result valid
- busy_o  output  1  stall request to the pipeline controller

Behaviour:
- Clock domain: clk only. Reset: rst is synchronous, active-high, and has priority over every state.
  - Reset values: state=IDLE, cnt=0, work reg=0, result_o=0, ready_o=0.
- States: IDLE, BYZERO, RUN, DONE.
- IDLE
  - start_i=1 and annul_i=0 with opdata2_i=0 → BYZERO.
  - start_i=1 and annul_i=0 with opdata2_i≠0 → RUN.
    - Latch magnitudes: if signed_div_i and the operand MSB=1, use the two's-complement negation; otherwise use the raw value.
    - Latch the operand signs and signed_div_i.
    - work[2W:0] = {W+1 zeros, |dividend|}, then shift left by 1. cnt=0.
  - Otherwise stay in IDLE.
- RUN: one iteration per cycle.
  - diff = work[2W:W] − {0, |divisor|}.
  - If diff is negative: work = work<<1, LSB=0.
  - Else: work = {diff[W−1:0], work[W−1:0], 1}.
  - cnt++. On the iteration with cnt=W−1 → DONE.
- DONE
  - Quotient = work[W−1:0]; remainder = work[2W:W+1].
  - If signed: negate the quotient when the operand signs differ; negate the remainder when the dividend was negative.
  - result_o is registered on the RUN→DONE edge. ready_o=1 throughout DONE.
  - Stay in DONE while start_i=1. start_i=0 → IDLE, ready_o=0.
- BYZERO: result_o=0 → DONE on the next edge.
- annul_i=1 in RUN or BYZERO → IDLE next edge. ready_o is never asserted, and result_o keeps its prior value.
- annul_i in DONE → IDLE.
- busy_o is combinational. It is 1 when:
  - state ∈ {RUN, BYZERO}, or
  - state=IDLE and start_i=1 and annul_i=0.
  - It is 0 in DONE, which releases the stall in the same cycle the result is valid.
- Latency (cycle 0 = start sampled in IDLE):
  - Nonzero divisor: ready_o high from cycle W+1 (cycle 33 for W=32).
  - Zero divisor: ready_o high from cycle 2.
- Operands are sampled only in the IDLE→RUN/BYZERO transition. Input changes mid-run are ignored.
- Overflow case, signed 0x80000000 / −1: quotient=0x80000000, remainder=0. This falls naturally out of the magnitude path; no special case is required.
- Unsigned: no sign correction.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - Adds port div_zero_o (output, 1 bit).
  - div_zero_o=1 exactly when ready_o=1 and the operation passed through BYZERO; otherwise 0.
  - Reset value 0.
- Undefined: the port is absent; divide-by-zero still returns result_o=0 with identical timing.

Decomposition:
- Shared defines header:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2 bits)
  - DivResultReady/DivResultNotReady
  - DivStart/DivStop
  - ZeroWord
  - RegBus width
  - DoubleRegBus
- Sub-module div_step: combinational single iteration.
  - Inputs: work, divisor. Output: next work.
  - Lets a future unrolled radix-4 variant instantiate it twice.

Test Plan:
- Unsigned 100/7: start held → busy_o=1 for cycles 0–32; ready_o at cycle 33; result_o={0x00000002, 0x0000000E}. Drop start → IDLE next cycle, ready_o=0.
- Signed −7/2 (0xFFFFFFF9, 0x00000002): result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/−2: {0x00000001, 0xFFFFFFFD}.
- Divisor 0, dividend 0x12345678: ready_o at cycle 2, result_o=0. With DIV_ZERO_FLAG_EN: div_zero_o=1 alongside ready_o.
- annul_i pulsed at cycle 10 of a run: IDLE at cycle 11, busy_o=0, ready_o never asserted. An immediate new start 9/3 yields {0, 3} at cycle 33 relative to its own start.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- rst asserted at cycle 15 of a run: next cycle state IDLE, result_o=0, ready_o=0, busy_o follows start_i only.
